operand_reader: RTL and testbench

Input-side front end for the LED adder demo: takes raw board switches and two push buttons, synchronises and debounces them, and captures two WIDTH-bit operands in sequence. It presents the operand pair to the downstream adder over a valid/ready handshake. The adder drives the LEDs; this block is the producer end, reading what the user enters.

---
 rtl/operand_reader_pkg.sv | 21 ++
 rtl/operand_reader_btn.sv | 68 ++++++
 rtl/operand_reader.sv | 135 +++++++++++++
 tb/tb_operand_reader.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/operand_reader_pkg.sv
// operand_reader_pkg
// Shared definitions for the operand reader front end:
//   phase_t                  - FSM state encoding, also driven out on the phase port
//   DEBOUNCE_CYCLES_DEFAULT  - 1 ms of debounce at a 12 MHz system clock
//   debounce_cnt_width()     - width of the debounce counter for a given cycle count
package operand_reader_pkg;

  typedef enum logic [1:0] {
    GET_A = 2'd0,
    GET_B = 2'd1,
    HOLD  = 2'd2
  } phase_t;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 12000;

  // The counter only has to reach DEBOUNCE_CYCLES-1, so $clog2 bits suffice.
  function automatic int debounce_cnt_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/operand_reader_btn.sv
// btn_debounce
// Synchronises one raw push-button pin, debounces it and emits a one-cycle
// registered pulse on each debounced press (0->1 of the stable level).
// Ports:
//   clk    system clock
//   rst    asynchronous active-high reset
//   raw    raw button pin
//   press  one-cycle press pulse
// Parameters:
//   DEBOUNCE_CYCLES  consecutive mismatching synchronised cycles needed to
//                    accept a new level (>= 2)
//   IDLE_LEVEL       pin level when the button is not pressed
module btn_debounce
  import operand_reader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter bit IDLE_LEVEL      = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  localparam int CW = debounce_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic          level;
  logic          stable;
  logic          stable_d;
  logic [CW-1:0] cnt;

  // The flops hold the pin level and reset to its idle value, so a pull-up
  // button idling high produces no activity when reset is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= {2{IDLE_LEVEL}};
    else     sync <= {sync[0], raw};
  end

  // Logical "pressed" level, independent of pin polarity.
  assign level = sync[1] ^ IDLE_LEVEL;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (level == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      stable <= level;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_d <= 1'b0;
      press    <= 1'b0;
    end else begin
      stable_d <= stable;
      press    <= stable & ~stable_d;
    end
  end

endmodule

// File: rtl/operand_reader.sv
// operand_reader
// Producer end of the LED adder demo: synchronises the operand switches,
// debounces the enter/clear buttons and captures two operands in sequence,
// then offers the pair downstream on a valid/ready handshake.
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   sw         raw operand switches (WIDTH bits)
//   btn_enter  raw enter button
//   btn_clear  raw clear button
//   op_a       first captured operand
//   op_b       second captured operand
//   valid      operand pair available
//   ready      downstream accepts the pair when valid && ready
//   phase      FSM state for status LEDs (0 GET_A, 1 GET_B, 2 HOLD)
// Build option:
//   BTN_ACTIVE_LOW_EN  buttons are pull-up (idle pin 1, pressed 0)
//
// state | meaning
// GET_A | waiting for enter to capture op_a
// GET_B | waiting for enter to capture op_b
// HOLD  | pair valid and frozen until the handshake
module operand_reader
  import operand_reader_pkg::*;
#(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_enter,
  input  logic             btn_clear,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             valid,
  input  logic             ready,
  output logic [1:0]       phase
);

`ifdef BTN_ACTIVE_LOW_EN
  localparam bit BTN_IDLE = 1'b1;
`else
  localparam bit BTN_IDLE = 1'b0;
`endif

  logic [WIDTH-1:0] sw_meta;
  logic [WIDTH-1:0] sw_sync;
  logic             enter_press;
  logic             clear_press;
  phase_t           state;
  phase_t           state_n;
  logic [WIDTH-1:0] op_a_n;
  logic [WIDTH-1:0] op_b_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
    end
  end

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .IDLE_LEVEL     (BTN_IDLE)
  ) u_enter (
    .clk  (clk),
    .rst  (rst),
    .raw  (btn_enter),
    .press(enter_press)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .IDLE_LEVEL     (BTN_IDLE)
  ) u_clear (
    .clk  (clk),
    .rst  (rst),
    .raw  (btn_clear),
    .press(clear_press)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= GET_A;
    else     state <= state_n;
  end

  // Clear outranks both enter and a handshake; valid is high exactly in HOLD,
  // so a handshake there reduces to ready.
  always_comb begin
    state_n = state;
    if (clear_press) begin
      state_n = GET_A;
    end else begin
      case (state)
        GET_A:   if (enter_press) state_n = GET_B;
        GET_B:   if (enter_press) state_n = HOLD;
        HOLD:    if (ready)       state_n = GET_A;
        default: state_n = GET_A;
      endcase
    end
  end

  always_comb begin
    op_a_n = op_a;
    op_b_n = op_b;
    if (clear_press) begin
      op_a_n = '0;
      op_b_n = '0;
    end else if (enter_press && state == GET_A) begin
      op_a_n = sw_sync;
    end else if (enter_press && state == GET_B) begin
      op_b_n = sw_sync;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a <= '0;
      op_b <= '0;
    end else begin
      op_a <= op_a_n;
      op_b <= op_b_n;
    end
  end

  always_comb begin
    valid = (state == HOLD);
    phase = state;
  end

endmodule

// File: tb/tb_operand_reader.sv
module tb_operand_reader;

  localparam int W = 2;
  localparam int D = 4;
`ifdef BTN_ACTIVE_LOW_EN
  localparam bit AL = 1'b1;
`else
  localparam bit AL = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] sw;
  logic         btn_enter;
  logic         btn_clear;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         valid;
  logic         ready;
  logic [1:0]   phase;

  int checks = 0;
  int failures = 0;

  operand_reader #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .sw       (sw),
    .btn_enter(btn_enter),
    .btn_clear(btn_clear),
    .op_a     (op_a),
    .op_b     (op_b),
    .valid    (valid),
    .ready    (ready),
    .phase    (phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         action;   // 0 idle, 1 enter, 2 clear
    logic [1:0] sw_val;
    logic       rdy;
    logic [1:0] exp_a;
    logic [1:0] exp_b;
    logic       exp_valid;
    logic [1:0] exp_phase;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input logic enter_on, input logic clear_on);
    btn_enter = enter_on ^ AL;
    btn_clear = clear_on ^ AL;
  endtask

  task automatic press_enter(input logic [1:0] s);
    sw = s;
    set_btn(1'b1, 1'b0);
    tick(8);
    set_btn(1'b0, 1'b0);
    tick(12);
  endtask

  task automatic press_clear();
    set_btn(1'b0, 1'b1);
    tick(8);
    set_btn(1'b0, 1'b0);
    tick(12);
  endtask

  task automatic check_all(input string name, input int a, input int b,
                           input int v, input int p);
    check({name, "_op_a"}, int'(op_a), a);
    check({name, "_op_b"}, int'(op_b), b);
    check({name, "_valid"}, int'(valid), v);
    check({name, "_phase"}, int'(phase), p);
  endtask

  initial begin
    //            act sw    rdy   a     b     v     phase
    vecs[0] = '{1, 2'd2, 1'b0, 2'd2, 2'd0, 1'b0, 2'd1};
    vecs[1] = '{1, 2'd3, 1'b0, 2'd2, 2'd3, 1'b1, 2'd2};
    vecs[2] = '{1, 2'd1, 1'b0, 2'd2, 2'd3, 1'b1, 2'd2};
    vecs[3] = '{0, 2'd0, 1'b1, 2'd2, 2'd3, 1'b0, 2'd0};
    vecs[4] = '{1, 2'd1, 1'b1, 2'd1, 2'd3, 1'b0, 2'd1};
    vecs[5] = '{2, 2'd0, 1'b1, 2'd0, 2'd0, 1'b0, 2'd0};
    vecs[6] = '{1, 2'd3, 1'b1, 2'd3, 2'd0, 1'b0, 2'd1};
    vecs[7] = '{1, 2'd2, 1'b1, 2'd3, 2'd2, 1'b0, 2'd0};

    rst = 1'b1;
    sw = '0;
    ready = 1'b1;
    set_btn(1'b0, 1'b0);
    tick(3);
    check_all("reset", 0, 0, 0, 0);
    rst = 1'b0;
    tick(20);
    check_all("idle_after_reset", 0, 0, 0, 0);

    // Normal entry with exact latency on the second operand.
    press_enter(2'b10);
    check("entry_a_op_a", int'(op_a), 2);
    check("entry_a_phase", int'(phase), 1);
    sw = 2'b11;
    set_btn(1'b1, 1'b0);
    tick(7);
    check("lat_c7_valid", int'(valid), 0);
    check("lat_c7_phase", int'(phase), 1);
    tick(1);
    check_all("lat_c8", 2, 3, 1, 2);
    tick(1);
    check("handshake_valid", int'(valid), 0);
    check("handshake_phase", int'(phase), 0);
    set_btn(1'b0, 1'b0);
    tick(12);

    // Bounce: 2-cycle pulses never reach the debounce threshold.
    sw = 2'b01;
    repeat (3) begin
      set_btn(1'b1, 1'b0);
      tick(2);
      set_btn(1'b0, 1'b0);
      tick(2);
    end
    tick(15);
    check("bounce_phase", int'(phase), 0);
    check("bounce_op_a", int'(op_a), 2);

    // Backpressure.
    ready = 1'b0;
    press_enter(2'd1);
    press_enter(2'd2);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("bp_valid_held", int'(valid), 1);
    end
    press_enter(2'd3);
    check_all("bp_enter_ignored", 1, 2, 1, 2);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    check("bp_release_valid", int'(valid), 0);
    check("bp_release_phase", int'(phase), 0);

    // Clear beats a simultaneous enter and handshake in HOLD.
    press_enter(2'd3);
    press_enter(2'd1);
    check_all("pre_clear_hold", 3, 1, 1, 2);
    set_btn(1'b1, 1'b1);
    tick(7);
    check("clr_c7_valid", int'(valid), 1);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    check_all("clr_hold", 0, 0, 0, 0);
    set_btn(1'b0, 1'b0);
    tick(12);
    check("clr_hold_settled_phase", int'(phase), 0);

    // Clear during GET_B.
    ready = 1'b1;
    press_enter(2'd2);
    check("getb_phase", int'(phase), 1);
    press_clear();
    check("clr_getb_phase", int'(phase), 0);
    check("clr_getb_op_a", int'(op_a), 0);

    // Table-driven vectors.
    for (int i = 0; i < 8; i++) begin
      ready = vecs[i].rdy;
      if (vecs[i].action == 1)      press_enter(vecs[i].sw_val);
      else if (vecs[i].action == 2) press_clear();
      else                          tick(20);
      check_all($sformatf("vec%0d", i), int'(vecs[i].exp_a), int'(vecs[i].exp_b),
                int'(vecs[i].exp_valid), int'(vecs[i].exp_phase));
    end

    // Asynchronous reset mid-operation, then a button held through release.
    ready = 1'b0;
    press_enter(2'd1);
    press_enter(2'd2);
    check_all("pre_rst", 1, 2, 1, 2);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_all("async_rst", 0, 0, 0, 0);
    sw = 2'd3;
    set_btn(1'b1, 1'b0);
    tick(2);
    rst = 1'b0;
    tick(6);
    check("held_thru_rst_early", int'(phase), 0);
    tick(6);
    check("held_thru_rst_phase", int'(phase), 1);
    check("held_thru_rst_op_a", int'(op_a), 3);
    set_btn(1'b0, 1'b0);
    tick(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
